// File: rtl/rsa_pkg.sv
// Shared constants and state types for the RSA encrypt/decrypt datapaths.
// Holds the operand width, multiplier latency and controller/multiplier FSM encodings.
package rsa_pkg;
    localparam int RSA_WIDTH  = 256;
    localparam int MM_LATENCY = RSA_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REDUCE,
        SQUARE,
        MULT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_RUN,
        MM_FIN
    } mm_state_e;
endpackage

// File: rtl/mod_mult_serial.sv
// Bit-serial interleaved modular multiplier: p = (a * b) mod n, needs b < n.
// Ports: clk, reset (sync, active-high), start, a, b, n -> p, done (1-cycle pulse).
module mod_mult_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mm_state_e        st_q, st_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH+1:0] r_q, r_d;
    logic [CW-1:0]    k_q, k_d;

    logic [WIDTH+1:0] n_ext, r_dbl, r_sub, r_add, r_nxt;

    // One interleaved step; R < n keeps every intermediate below 2n.
    always_comb begin
        n_ext = {2'b00, n_q};
        r_dbl = r_q << 1;
        r_sub = (r_dbl >= n_ext) ? r_dbl - n_ext : r_dbl;
        r_add = a_q[WIDTH-1] ? r_sub + {2'b00, b_q} : r_sub;
        r_nxt = (r_add >= n_ext) ? r_add - n_ext : r_add;
    end

    always_comb begin
        st_d = st_q;
        a_d  = a_q;
        b_d  = b_q;
        n_d  = n_q;
        r_d  = r_q;
        k_d  = k_q;
        unique case (st_q)
            MM_IDLE: begin
                if (start) begin
                    a_d  = a;
                    b_d  = b;
                    n_d  = n;
                    r_d  = '0;
                    k_d  = CW'(WIDTH - 1);
                    st_d = MM_RUN;
                end
            end
            MM_RUN: begin
                r_d = r_nxt;
                a_d = a_q << 1;
                if (k_q == '0) begin
                    st_d = MM_FIN;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            MM_FIN: st_d = MM_IDLE;
            default: st_d = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= MM_IDLE;
            a_q  <= '0;
            b_q  <= '0;
            n_q  <= '0;
            r_q  <= '0;
            k_q  <= '0;
        end else begin
            st_q <= st_d;
            a_q  <= a_d;
            b_q  <= b_d;
            n_q  <= n_d;
            r_q  <= r_d;
            k_q  <= k_d;
        end
    end

    assign p    = r_q[WIDTH-1:0];
    assign done = (st_q == MM_FIN);
endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption M = C^d mod n via left-to-right square-and-multiply.
// Ports: clk, reset (sync, active-high), d, n, C, ready -> M, valid.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] C,
    input  logic             ready,
    output logic [WIDTH-1:0] M,
    output logic             valid
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d, n_q, n_d, c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d, base_q, base_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic             mm_start, mm_done, op_state;
    logic [WIDTH-1:0] mm_a, mm_b, mm_p;

    assign op_state = (state_q == REDUCE) || (state_q == SQUARE) ||
                      (state_q == MULT);
    // A new product is issued the cycle after the previous one completes.
    assign mm_start = op_state && !busy_q;

    always_comb begin
        mm_a = '0;
        mm_b = '0;
        unique case (state_q)
            REDUCE: begin
                mm_a = c_q;
                mm_b = WIDTH'(1);
            end
            SQUARE: begin
                mm_a = res_q;
                mm_b = res_q;
            end
            MULT: begin
                mm_a = res_q;
                mm_b = base_q;
            end
            default: ;
        endcase
    end

    mod_mult_serial #(.WIDTH(WIDTH)) u_mm (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .n     (n_q),
        .p     (mm_p),
        .done  (mm_done)
    );

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        n_d     = n_q;
        c_d     = c_q;
        res_d   = res_q;
        base_d  = base_q;
        m_d     = m_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        if (mm_start) begin
            busy_d = 1'b1;
        end else if (mm_done) begin
            busy_d = 1'b0;
        end
        unique case (state_q)
            IDLE, DONE: begin
                if (ready) begin
                    d_d     = d;
                    n_d     = n;
                    c_d     = C;
                    valid_d = 1'b0;
                    state_d = LOAD;
                end else if (state_q == DONE) begin
                    m_d     = res_q;
                    valid_d = 1'b1;
                end
            end
            LOAD: begin
                if (n_q < WIDTH'(2)) begin
                    res_d   = '0;
                    state_d = DONE;
                end else begin
                    res_d   = WIDTH'(1);
                    idx_d   = CW'(WIDTH - 1);
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (mm_done) begin
                    base_d  = mm_p;
                    state_d = SQUARE;
                end
            end
            SQUARE: begin
                if (mm_done) begin
                    res_d = mm_p;
                    if (d_q[idx_q]) begin
                        state_d = MULT;
                    end else if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            MULT: begin
                if (mm_done) begin
                    res_d = mm_p;
                    if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = SQUARE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            d_q     <= '0;
            n_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            base_q  <= '0;
            m_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            n_q     <= n_d;
            c_q     <= c_d;
            res_q   <= res_d;
            base_q  <= base_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign M     = m_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_rsa_decrypt.sv
// Directed bench for rsa_decrypt at a reduced width to keep runtime short.
// Checks results, latency, reset, busy-ready, back-to-back and key round trips.
module tb_rsa_decrypt;
    import rsa_pkg::*;

    localparam int W     = 32;
    localparam int LIMIT = 5000;

    logic         clk;
    logic         reset;
    logic [W-1:0] d, n, C, M;
    logic         ready, valid;

    int vectors;
    int miscompares;

    rsa_decrypt #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .n     (n),
        .C     (C),
        .ready (ready),
        .M     (M),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic int lat(input logic [W-1:0] dd);
        return 2 + (W + 2) * (W + 1 + $countones(dd));
    endfunction

    function automatic longint unsigned modexp(
        input longint unsigned b, input longint unsigned e,
        input longint unsigned m);
        longint unsigned r, bb;
        if (m < 2) return 0;
        r  = 1;
        bb = b % m;
        for (int i = 63; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * bb) % m;
        end
        return r;
    endfunction

    function automatic longint unsigned modinv(
        input longint a, input longint m);
        longint t, nt, r, nr, q, tmp;
        t = 0; nt = 1; r = m; nr = a;
        while (nr != 0) begin
            q   = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + m;
        return longint'(t);
    endfunction

    task automatic start_op(input logic [W-1:0] dd, input logic [W-1:0] nn,
                            input logic [W-1:0] cc);
        @(negedge clk);
        d = dd; n = nn; C = cc; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got %b want 0", valid);
        end
        vectors++;
        if (M !== '0) begin
            miscompares++;
            $display("FAIL reset_M got %0d want 0", M);
        end
        reset = 1'b0;
    endtask

    task automatic test_textbook();
        int cyc;
        start_op(W'(2753), W'(3233), W'(2790));
        wait_valid(cyc);
        vectors++;
        if (M !== W'(65)) begin
            miscompares++;
            $display("FAIL textbook_M got %0d want 65", M);
        end
        vectors++;
        if (cyc != lat(W'(2753))) begin
            miscompares++;
            $display("FAIL textbook_lat got %0d want %0d", cyc, lat(W'(2753)));
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || M !== W'(65)) begin
            miscompares++;
            $display("FAIL textbook_hold got v=%b M=%0d want v=1 M=65", valid, M);
        end
    endtask

    task automatic test_unreduced();
        int cyc;
        start_op(W'(2753), W'(3233), W'(6023));
        wait_valid(cyc);
        vectors++;
        if (M !== W'(65) || cyc != lat(W'(2753))) begin
            miscompares++;
            $display("FAIL unreduced got M=%0d lat=%0d want M=65 lat=%0d",
                     M, cyc, lat(W'(2753)));
        end
    endtask

    task automatic test_zero_exp();
        int cyc;
        start_op(W'(0), W'(3233), W'(1234));
        wait_valid(cyc);
        vectors++;
        if (M !== W'(1) || cyc != lat(W'(0))) begin
            miscompares++;
            $display("FAIL zero_exp got M=%0d lat=%0d want M=1 lat=%0d",
                     M, cyc, lat(W'(0)));
        end
    endtask

    task automatic test_small_mod();
        int cyc;
        logic [W-1:0] mods [2];
        mods[0] = W'(1);
        mods[1] = W'(0);
        foreach (mods[k]) begin
            start_op(W'(2753), mods[k], W'(55));
            wait_valid(cyc);
            vectors++;
            if (M !== '0 || cyc != 2) begin
                miscompares++;
                $display("FAIL small_mod n=%0d got M=%0d lat=%0d want M=0 lat=2",
                         mods[k], M, cyc);
            end
        end
    endtask

    task automatic test_busy_ready();
        int cyc;
        start_op(W'(2753), W'(3233), W'(2790));
        repeat (100) @(negedge clk);
        d = W'(7); n = W'(11); C = W'(5); ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        wait_valid(cyc);
        cyc = cyc + 101;
        vectors++;
        if (M !== W'(65) || cyc != lat(W'(2753))) begin
            miscompares++;
            $display("FAIL busy_ready got M=%0d lat=%0d want M=65 lat=%0d",
                     M, cyc, lat(W'(2753)));
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op(W'(2753), W'(3233), W'(2790));
        repeat (1000) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (valid !== 1'b0 || M !== '0 || dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL reset_mid got v=%b M=%0d st=%0d want v=0 M=0 st=IDLE",
                     valid, M, dut.state_q);
        end
        reset = 1'b0;
        start_op(W'(2753), W'(3233), W'(2790));
        wait_valid(cyc);
        vectors++;
        if (M !== W'(65) || cyc != lat(W'(2753))) begin
            miscompares++;
            $display("FAIL reset_restart got M=%0d lat=%0d want M=65 lat=%0d",
                     M, cyc, lat(W'(2753)));
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [W-1:0] exp_m;
        exp_m = W'(modexp(64'd2557, 64'd2753, 64'd3233));
        start_op(W'(2753), W'(3233), W'(2557));
        vectors++;
        if (valid !== 1'b0 || M !== W'(65)) begin
            miscompares++;
            $display("FAIL b2b_drop got v=%b M=%0d want v=0 M=65", valid, M);
        end
        wait_valid(cyc);
        vectors++;
        if (M !== exp_m || cyc != lat(W'(2753))) begin
            miscompares++;
            $display("FAIL b2b_result got M=%0d lat=%0d want M=%0d lat=%0d",
                     M, cyc, exp_m, lat(W'(2753)));
        end
    endtask

    task automatic test_round_trip();
        int cyc;
        longint unsigned p [3], q [3];
        longint unsigned nn, phi, dd, mm, cc;
        p[0] = 61;    q[0] = 53;
        p[1] = 65521; q[1] = 65519;
        p[2] = 65521; q[2] = 61;
        foreach (p[k]) begin
            nn  = p[k] * q[k];
            phi = (p[k] - 1) * (q[k] - 1);
            dd  = modinv(65537, longint'(phi));
            mm  = longint'($urandom) % nn;
            cc  = modexp(mm, 65537, nn);
            start_op(W'(dd), W'(nn), W'(cc));
            wait_valid(cyc);
            vectors++;
            if (M !== W'(mm) || cyc != lat(W'(dd))) begin
                miscompares++;
                $display("FAIL round_trip n=%0d got M=%0d lat=%0d want M=%0d lat=%0d",
                         nn, M, cyc, mm, lat(W'(dd)));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk   = 1'b0;
        reset = 1'b1;
        ready = 1'b0;
        d = '0; n = '0; C = '0;
        test_reset();
        test_textbook();
        test_unreduced();
        test_zero_exp();
        test_small_mod();
        test_textbook();
        test_busy_ready();
        test_reset_mid();
        test_back_to_back();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rsa_decrypt.md
# rsa_decrypt

- RSA decryption engine. Computes M = C^d mod n for WIDTH-bit operands.
- Consumes the ciphertext produced by the `encrypt` path and recovers the plaintext.
- Uses a left-to-right binary square-and-multiply controller over a bit-serial interleaved modular multiplier.
- Latency is deterministic given popcount(d).

## Interface
- WIDTH, 256, operand/result width in bits
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, reset sampled on clk
- d  input  WIDTH  private exponent, sampled when ready accepted
- n  input  WIDTH  modulus, sampled when ready accepted
- C  input  WIDTH  ciphertext, sampled when ready accepted; any value (need not be < n)
- ready  input  1  start request; accepted only in IDLE or DONE
- M  output  WIDTH  plaintext; reset value 0
- valid  output  1  high while M holds a completed result; reset value 0

## Operation
- States: IDLE, LOAD, REDUCE, SQUARE, MULT, DONE.
- IDLE/DONE + ready:
  - Register d, n, C.
  - Clear valid.
  - Go to LOAD.
- ready in any other state is ignored. Inputs are not re-sampled mid-operation.
- LOAD:
  - If n < 2: M = 0, go to DONE.
  - Else: res = 1, bit index i = WIDTH-1, go to REDUCE.
- REDUCE: base = mod_mult(C, 1) = C mod n, then go to SQUARE.
- SQUARE: res = mod_mult(res, res).
  - If d[i] = 1: go to MULT.
  - Else if i = 0: go to DONE.
  - Else: i = i-1, stay in SQUARE.
- MULT: res = mod_mult(res, base).
  - If i = 0: go to DONE.
  - Else: i = i-1, go to SQUARE.
- All WIDTH exponent bits are processed, including leading zeros. No early skip.
- DONE: M = res, valid = 1. Both hold until ready is accepted or reset.
- mod_mult(a, b) requires b < n; a is unrestricted. Interleaved algorithm, MSB of a first:
  - R = 2R
  - if R >= n: R -= n
  - if a[k]: R += b
  - if R >= n: R -= n
- R is WIDTH+2 bits internally. The result is < n and is truncated to WIDTH bits.
- d = 0 with n >= 2 gives M = 1.

## Timing
- Each mod_mult invocation occupies exactly WIDTH+2 cycles: issue cycle, WIDTH iteration cycles, completion cycle.
- Latency from the edge sampling ready to the first cycle valid = 1:
  - 2 + (WIDTH+2)·(WIDTH+1+popcount(d))
  - For WIDTH=256: 2 + 258·(257+popcount(d)).
- n < 2: valid = 1 exactly 2 cycles after ready is sampled.
- ready accepted while valid = 1: valid falls the next cycle. M keeps its old value until the new result loads.
- reset mid-operation: next cycle state = IDLE, valid = 0, M = 0. The multiplier's internal start/busy is cleared.
- reset and ready asserted in the same cycle: reset wins.

## Structure
- Shared package rsa_pkg holds:
  - RSA_WIDTH = 256
  - MM_LATENCY = RSA_WIDTH+2
  - the state enum typedef
- The encrypt path uses the same constants.
- One sub-module: mod_mult_serial.
  - Ports: clk, reset, start, a, b, n, p, done.
  - done is a one-cycle pulse.
  - It is reusable by square_and_multiply.
- The controller handles operand muxing (res/base/1), the bit index counter, and the result register.

## Test plan
- Textbook key, WIDTH=256 zero-extended: n=3233, d=2753, C=2790 -> M=65, valid after exactly 2+258·262 = 67598 cycles.
- Unreduced input: n=3233, d=2753, C=6023 -> M=65. d=0, n=3233, C=1234 -> M=1.
- n=1 and n=0 with any d, C -> M=0, valid 2 cycles after ready. ready pulsed during busy is ignored and the result is unchanged.
- Reset asserted 1000 cycles into the textbook case -> next cycle valid=0, M=0, state IDLE. A fresh ready then yields M=65 at full latency.
- Back-to-back operation: ready asserted while valid=1 with a new C=2557 (65 → 2790, 2557 → ?) -> valid drops next cycle, then asserts with the golden-model result.
- Randomized 256-bit round trip: encrypt M with e=65537, then decrypt with the matching d -> recovered M equals the original. Cycle count matches the latency formula for each d.
